umi_endpoint: RTL and testbench



---
 rtl/umi_endpoint.sv | 233 +++++++++++++++++++++++
 tb/tb_umi_endpoint.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/umi_endpoint.sv
// UMI terminating endpoint: decodes request packets, executes them against a
// single-cycle local memory port and returns WRITE_RESPONSE packets for
// acknowledged writes, reads and atomics. One transaction in flight at a time.

// Opcode classifier for {cmd, write}; atomics carry their subtype in opcode[7:4].
module umi_decode (
  input  logic [6:0] cmd,
  input  logic       write,
  output logic       write_plain,
  output logic       write_ack,
  output logic       read_request,
  output logic       atomic,
  output logic [3:0] atomic_type
);

  logic [7:0] opcode;

  assign opcode      = {cmd, write};
  assign atomic_type = opcode[7:4];

  // Low nibble selects the transaction class; unknown codes decode to nothing.
  always_comb begin
    write_plain  = 1'b0;
    write_ack    = 1'b0;
    read_request = 1'b0;
    atomic       = 1'b0;
    case (opcode[3:0])
      4'h1, 4'h3, 4'h7: write_plain  = 1'b1;  // posted, signal, stream
      4'h9:             write_ack    = 1'b1;
      4'h2:             read_request = 1'b1;
      4'h4:             atomic       = (opcode[7:4] <= 4'h8);
      default: ;
    endcase
  end

endmodule

module umi_endpoint #(
  parameter int unsigned AW = 64,
  parameter int unsigned DW = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  input  logic [6:0]    req_cmd,
  input  logic          req_write,
  input  logic [AW-1:0] req_dstaddr,
  input  logic [AW-1:0] req_srcaddr,
  input  logic [DW-1:0] req_data,
  output logic          req_ready,
  output logic          resp_valid,
  output logic [6:0]    resp_cmd,
  output logic          resp_write,
  output logic [AW-1:0] resp_dstaddr,
  output logic [AW-1:0] resp_srcaddr,
  output logic [DW-1:0] resp_data,
  input  logic          resp_ready,
  output logic          loc_read,
  output logic          loc_write,
  output logic [AW-1:0] loc_addr,
  output logic [DW-1:0] loc_wrdata,
  input  logic [DW-1:0] loc_rddata,
  output logic          err
);

  localparam logic [7:0] WRITE_RESPONSE = 8'h05;

  localparam logic [3:0] AMO_SWAP = 4'h0;
  localparam logic [3:0] AMO_ADD  = 4'h1;
  localparam logic [3:0] AMO_AND  = 4'h2;
  localparam logic [3:0] AMO_OR   = 4'h3;
  localparam logic [3:0] AMO_XOR  = 4'h4;
  localparam logic [3:0] AMO_MAX  = 4'h5;
  localparam logic [3:0] AMO_MIN  = 4'h6;
  localparam logic [3:0] AMO_MAXU = 4'h7;
  localparam logic [3:0] AMO_MINU = 4'h8;

  typedef enum logic [2:0] {IDLE, EXEC, WAIT, AWR, RESP} state_t;
  typedef enum logic [2:0] {K_WRITE, K_ACK, K_READ, K_ATOMIC, K_INVALID} kind_t;

  state_t        state;
  kind_t         kind;
  kind_t         dec_kind;
  logic [3:0]    atype;
  logic [AW-1:0] l_dstaddr;
  logic [AW-1:0] l_srcaddr;
  logic [DW-1:0] l_data;
  logic [DW-1:0] old;

  logic          dec_write_plain;
  logic          dec_write_ack;
  logic          dec_read;
  logic          dec_atomic;
  logic [3:0]    dec_atype;

  umi_decode u_decode (
    .cmd          (req_cmd),
    .write        (req_write),
    .write_plain  (dec_write_plain),
    .write_ack    (dec_write_ack),
    .read_request (dec_read),
    .atomic       (dec_atomic),
    .atomic_type  (dec_atype)
  );

  // Collapse decoder flags into the single class the FSM dispatches on.
  always_comb begin
    dec_kind = K_INVALID;
    if (dec_write_plain)    dec_kind = K_WRITE;
    else if (dec_write_ack) dec_kind = K_ACK;
    else if (dec_read)      dec_kind = K_READ;
    else if (dec_atomic)    dec_kind = K_ATOMIC;
  end

  // Read-modify-write result; compare-based ops keep the old value on ties.
  function automatic logic [DW-1:0] amo_result(input logic [3:0]    t,
                                               input logic [DW-1:0] prev,
                                               input logic [DW-1:0] opnd);
    logic [DW-1:0] r;
    r = prev;
    case (t)
      AMO_SWAP: r = opnd;
      AMO_ADD:  r = prev + opnd;
      AMO_AND:  r = prev & opnd;
      AMO_OR:   r = prev | opnd;
      AMO_XOR:  r = prev ^ opnd;
      AMO_MAX:  r = ($signed(opnd) > $signed(prev)) ? opnd : prev;
      AMO_MIN:  r = ($signed(opnd) < $signed(prev)) ? opnd : prev;
      AMO_MAXU: r = (opnd > prev) ? opnd : prev;
      AMO_MINU: r = (opnd < prev) ? opnd : prev;
      default:  r = prev;
    endcase
    return r;
  endfunction

  // Transaction FSM with all handshake, local-port and response outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      kind         <= K_INVALID;
      atype        <= 4'h0;
      l_dstaddr    <= '0;
      l_srcaddr    <= '0;
      l_data       <= '0;
      old          <= '0;
      req_ready    <= 1'b0;
      resp_valid   <= 1'b0;
      resp_cmd     <= 7'h0;
      resp_write   <= 1'b0;
      resp_dstaddr <= '0;
      resp_srcaddr <= '0;
      resp_data    <= '0;
      loc_read     <= 1'b0;
      loc_write    <= 1'b0;
      loc_addr     <= '0;
      loc_wrdata   <= '0;
      err          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            // Strobes launch here so they are seen during EXEC
            req_ready  <= 1'b0;
            kind       <= dec_kind;
            atype      <= dec_atype;
            l_dstaddr  <= req_dstaddr;
            l_srcaddr  <= req_srcaddr;
            l_data     <= req_data;
            loc_addr   <= req_dstaddr;
            loc_wrdata <= req_data;
            loc_write  <= (dec_kind == K_WRITE) || (dec_kind == K_ACK);
            loc_read   <= (dec_kind == K_READ) || (dec_kind == K_ATOMIC);
            state      <= EXEC;
          end
        end
        EXEC: begin
          loc_read     <= 1'b0;
          loc_write    <= 1'b0;
          // Header fields settle here and stay put through RESP
          resp_cmd     <= WRITE_RESPONSE[7:1];
          resp_write   <= WRITE_RESPONSE[0];
          resp_dstaddr <= l_srcaddr;
          resp_srcaddr <= l_dstaddr;
          case (kind)
            K_WRITE: begin
              req_ready <= 1'b1;
              state     <= IDLE;
            end
            K_ACK: begin
              resp_data  <= '0;
              resp_valid <= 1'b1;
              state      <= RESP;
            end
            K_READ, K_ATOMIC: state <= WAIT;
            default: begin
              err       <= 1'b1;
              req_ready <= 1'b1;
              state     <= IDLE;
            end
          endcase
        end
        WAIT: begin
          old <= loc_rddata;
          if (kind == K_ATOMIC) begin
            loc_write  <= 1'b1;
            loc_wrdata <= amo_result(atype, loc_rddata, l_data);
            state      <= AWR;
          end else begin
            resp_data  <= loc_rddata;
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        AWR: begin
          loc_write  <= 1'b0;
          resp_data  <= old;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_umi_endpoint.sv
// Randomized bench for umi_endpoint: a transaction-level model predicts the
// local-port activity, response timing/content and memory image of each request.
`timescale 1ns/1ps
module tb_umi_endpoint;

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic [6:0]    req_cmd;
  logic          req_write;
  logic [AW-1:0] req_dstaddr;
  logic [AW-1:0] req_srcaddr;
  logic [DW-1:0] req_data;
  logic          req_ready;
  logic          resp_valid;
  logic [6:0]    resp_cmd;
  logic          resp_write;
  logic [AW-1:0] resp_dstaddr;
  logic [AW-1:0] resp_srcaddr;
  logic [DW-1:0] resp_data;
  logic          resp_ready;
  logic          loc_read;
  logic          loc_write;
  logic [AW-1:0] loc_addr;
  logic [DW-1:0] loc_wrdata;
  logic [DW-1:0] loc_rddata;
  logic          err;

  int checks = 0;
  int errors = 0;

  logic [63:0] dev_mem [16];
  logic [63:0] ref_mem [16];
  logic        exp_err;

  umi_endpoint #(.AW(AW), .DW(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_cmd      (req_cmd),
    .req_write    (req_write),
    .req_dstaddr  (req_dstaddr),
    .req_srcaddr  (req_srcaddr),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_cmd     (resp_cmd),
    .resp_write   (resp_write),
    .resp_dstaddr (resp_dstaddr),
    .resp_srcaddr (resp_srcaddr),
    .resp_data    (resp_data),
    .resp_ready   (resp_ready),
    .loc_read     (loc_read),
    .loc_write    (loc_write),
    .loc_addr     (loc_addr),
    .loc_wrdata   (loc_wrdata),
    .loc_rddata   (loc_rddata),
    .err          (err)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] seed_val(input int i);
    return {32'(i) * 32'h9E37_79B9, 32'h0BAD_0000 | 32'(i)};
  endfunction

  // Local memory device: read data appears the cycle after loc_read.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) dev_mem[i] <= seed_val(i);
      loc_rddata <= '0;
    end else begin
      if (loc_read) loc_rddata <= dev_mem[loc_addr[6:3]];
      if (loc_write) dev_mem[loc_addr[6:3]] <= loc_wrdata;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) ref_mem[i] = seed_val(i);
    exp_err = 1'b0;
  endtask

  // 0 plain write, 1 acked write, 2 read, 3 atomic, 4 dropped
  function automatic int op_class(input logic [7:0] op);
    case (op[3:0])
      4'h1, 4'h3, 4'h7: return 0;
      4'h9:             return 1;
      4'h2:             return 2;
      4'h4:             return (op[7:4] <= 4'h8) ? 3 : 4;
      default:          return 4;
    endcase
  endfunction

  function automatic logic [63:0] amo_ref(input logic [3:0] sub, input logic [63:0] o,
                                          input logic [63:0] v);
    case (sub)
      4'h0: return v;
      4'h1: return o + v;
      4'h2: return o & v;
      4'h3: return o | v;
      4'h4: return o ^ v;
      4'h5: return ($signed(v) > $signed(o)) ? v : o;
      4'h6: return ($signed(v) < $signed(o)) ? v : o;
      4'h7: return (v > o) ? v : o;
      4'h8: return (v < o) ? v : o;
      default: return o;
    endcase
  endfunction

  // One request end to end: issue, observe strobes and response, then update model.
  task automatic do_txn(input logic [7:0] op, input logic [3:0] idx, input logic [63:0] data,
                        input logic [63:0] src, input int stall);
    logic [63:0] dst, old_v, new_v, exp_wdata, exp_rdata;
    logic [63:0] wr_addr, wr_data, rd_addr;
    int cls, exp_rd_k, exp_wr_k, exp_resp_k, exp_ready_k;
    int n_rd, n_wr, n_both, rd_at, wr_at, resp_at, ready_at, wait_cnt;
    dst = 64'h100 + (64'(idx) << 3);
    cls = op_class(op);
    old_v = ref_mem[idx];
    new_v = old_v;
    exp_wdata = data;
    exp_rdata = 64'h0;
    exp_rd_k = 0; exp_wr_k = 0; exp_resp_k = 0; exp_ready_k = 0;
    case (cls)
      0: begin exp_wr_k = 1; exp_ready_k = 2; new_v = data; end
      1: begin exp_wr_k = 1; exp_resp_k = 2; new_v = data; end
      2: begin exp_rd_k = 1; exp_resp_k = 3; exp_rdata = old_v; end
      3: begin
        exp_rd_k = 1; exp_wr_k = 3; exp_resp_k = 4; exp_rdata = old_v;
        exp_wdata = amo_ref(op[7:4], old_v, data); new_v = exp_wdata;
      end
      default: begin exp_ready_k = 2; exp_err = 1'b1; end
    endcase

    wait_cnt = 0;
    while (!req_ready && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (!req_ready) chk("accept_timeout", 64'(req_ready), 64'h1);
    req_valid = 1'b1; req_cmd = op[7:1]; req_write = op[0];
    req_dstaddr = dst; req_srcaddr = src; req_data = data;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;

    n_rd = 0; n_wr = 0; n_both = 0; rd_at = 0; wr_at = 0; resp_at = 0; ready_at = 0;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    for (int k = 1; k <= 12; k++) begin
      if (loc_read) begin n_rd++; rd_at = k; rd_addr = loc_addr; end
      if (loc_write) begin n_wr++; wr_at = k; wr_addr = loc_addr; wr_data = loc_wrdata; end
      if (loc_read && loc_write) n_both++;
      if (resp_valid) begin resp_at = k; break; end
      if (exp_resp_k == 0 && req_ready) begin ready_at = k; break; end
      @(negedge clk);
    end

    chk("rd_count", 64'(n_rd), 64'(exp_rd_k != 0));
    chk("wr_count", 64'(n_wr), 64'(exp_wr_k != 0));
    chk("rd_wr_overlap", 64'(n_both), 64'h0);
    if (exp_rd_k != 0) begin
      chk("rd_cycle", 64'(rd_at), 64'(exp_rd_k));
      chk("rd_addr", rd_addr, dst);
    end
    if (exp_wr_k != 0) begin
      chk("wr_cycle", 64'(wr_at), 64'(exp_wr_k));
      chk("wr_addr", wr_addr, dst);
      chk("wr_data", wr_data, exp_wdata);
    end
    chk("resp_cycle", 64'(resp_at), 64'(exp_resp_k));
    if (exp_resp_k == 0) chk("ready_cycle", 64'(ready_at), 64'(exp_ready_k));

    if (exp_resp_k != 0 && resp_at != 0) begin
      chk("resp_data", resp_data, exp_rdata);
      chk("resp_dst", resp_dstaddr, src);
      chk("resp_src", resp_srcaddr, dst);
      chk("resp_opcode", 64'({resp_cmd, resp_write}), 64'h05);
      chk("busy_ready", 64'(req_ready), 64'h0);
      for (int s = 0; s < stall; s++) begin
        if (s == 0) begin
          // Competing request that must be ignored while the response is held
          req_valid = 1'b1; req_cmd = 7'h00; req_write = 1'b1;
          req_dstaddr = 64'h178; req_data = {$urandom, $urandom};
        end
        @(negedge clk);
        chk("stall_valid", 64'(resp_valid), 64'h1);
        chk("stall_data", resp_data, exp_rdata);
        chk("stall_dst", resp_dstaddr, src);
        chk("stall_ready", 64'(req_ready), 64'h0);
      end
      resp_ready = 1'b1;
      req_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      resp_ready = 1'b0;
      chk("resp_drop", 64'(resp_valid), 64'h0);
      chk("ready_after_resp", 64'(req_ready), 64'h1);
    end
    ref_mem[idx] = new_v;
    chk("err", 64'(err), 64'(exp_err));
  endtask

  // Reset lands while an atomic waits for read data.
  task automatic reset_mid_atomic();
    int n_wr, n_resp;
    @(negedge clk);
    req_valid = 1'b1; req_cmd = 7'h0A; req_write = 1'b0;  // atomic add
    req_dstaddr = 64'h140; req_srcaddr = 64'h9000; req_data = 64'h1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_ready", 64'(req_ready), 64'h0);
    chk("rst_write", 64'(loc_write), 64'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    n_wr = 0; n_resp = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) chk("rst_release_ready", 64'(req_ready), 64'h1);
      if (loc_write) n_wr++;
      if (resp_valid) n_resp++;
    end
    chk("rst_no_write", 64'(n_wr), 64'h0);
    chk("rst_no_resp", 64'(n_resp), 64'h0);
    chk("rst_err_clear", 64'(err), 64'h0);
  endtask

  logic [7:0] op_tab [16] = '{8'h01, 8'h03, 8'h07, 8'h09, 8'h02, 8'h04, 8'h14, 8'h24,
                              8'h34, 8'h44, 8'h54, 8'h64, 8'h74, 8'h84, 8'h00, 8'h0B};

  initial begin
    logic [63:0] d;
    logic [7:0]  op;
    reset = 1'b1; req_valid = 1'b0; req_cmd = '0; req_write = 1'b0;
    req_dstaddr = '0; req_srcaddr = '0; req_data = '0; resp_ready = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("reset_ready", 64'(req_ready), 64'h0);
    chk("reset_resp_valid", 64'(resp_valid), 64'h0);
    chk("reset_strobes", 64'({loc_read, loc_write}), 64'h0);
    chk("reset_err", 64'(err), 64'h0);
    chk("reset_loc_addr", loc_addr, 64'h0);
    chk("reset_resp_data", resp_data, 64'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 64'(req_ready), 64'h1);

    do_txn(8'h01, 4'd0, 64'hDEAD, 64'h8000, 0);                 // posted
    do_txn(8'h09, 4'd0, 64'h1234, 64'h8000, 0);                 // acked write
    do_txn(8'h02, 4'd0, 64'h0, 64'h8000, 0);                    // read 0x1234
    do_txn(8'h01, 4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8008, 0);
    do_txn(8'h14, 4'd2, 64'h1, 64'h8010, 0);                    // add wraps to 0
    do_txn(8'h01, 4'd3, 64'h5, 64'h8018, 0);
    do_txn(8'h64, 4'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8020, 0);  // signed min
    do_txn(8'h01, 4'd3, 64'h5, 64'h8018, 0);
    do_txn(8'h84, 4'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8028, 1);  // unsigned min
    do_txn(8'h02, 4'd0, 64'h0, 64'h8030, 10);                   // backpressure
    do_txn(8'h00, 4'd4, 64'h77, 64'h8038, 0);                   // invalid
    do_txn(8'h03, 4'd5, 64'hABCD, 64'h8040, 0);                 // err stays set

    for (int t = 0; t < 80; t++) begin
      op = op_tab[$urandom_range(0, 15)];
      if ($urandom_range(0, 15) == 0) op = 8'h05;
      if ($urandom_range(0, 3) == 0) d = 64'($urandom_range(0, 8)) - 64'd4;
      else d = {$urandom, $urandom};
      do_txn(op, 4'($urandom_range(0, 14)), d, {$urandom, $urandom}, int'($urandom_range(0, 3)));
    end

    for (int i = 0; i < 16; i++) chk($sformatf("mem_%0d", i), dev_mem[i], ref_mem[i]);

    reset_mid_atomic();
    do_txn(8'h02, 4'd8, 64'h0, 64'hA000, 0);                    // image reloaded

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
